// File: rtl/ep4_cmd_deframer_pkg.sv
// ep4_cmd_deframer_pkg: parser state encodings and default frame/timeout sizing
package ep4_cmd_deframer_pkg;
  typedef enum logic [2:0] {
    HDR_ID    = 3'd0,
    HDR_LEN_H = 3'd1,
    HDR_LEN_L = 3'd2,
    PAYLOAD   = 3'd3,
    DRAIN     = 3'd4,
    RETIRE    = 3'd5
  } state_t;
  localparam int DEF_MAX_COMMAND_LENGTH = 8;
  localparam int DEF_TIMEOUT_CYCLES     = 1024;
  localparam int DEF_TIMEOUT_WIDTH      = 11;
endpackage

// File: rtl/ep4_cmd_deframer_if.sv
// ep4_cmd_deframer_if: USB byte stream in, EP4 command port out
interface ep4_cmd_deframer_if;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  ep4_cmd_id;
  logic [15:0] ep4_cmd_length;
  logic        cmd_valid;
  logic        ep4_ready;
  logic        ep4_read;
  logic [7:0]  ep4_data;
  logic        err_oversize;
  logic        err_timeout;
  modport master (
    input  in_data, in_valid, ep4_read,
    output in_ready, ep4_cmd_id, ep4_cmd_length, cmd_valid, ep4_ready, ep4_data, err_oversize, err_timeout
  );
  modport slave (
    output in_data, in_valid, ep4_read,
    input  in_ready, ep4_cmd_id, ep4_cmd_length, cmd_valid, ep4_ready, ep4_data, err_oversize, err_timeout
  );
endinterface

// File: rtl/ep4_cmd_deframer_cmd_byte_fifo.sv
// cmd_byte_fifo: power-of-two byte FIFO with flush and combinational head
module cmd_byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [7:0]               din,
  output logic [7:0]               head,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wp, rp;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else if (flush) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      wp    <= push ? wp + 1'b1 : wp;
      rp    <= pop ? rp + 1'b1 : rp;
      count <= count + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge clk) if (push) mem[wp] <= din;
  assign head  = mem[rp];
  assign empty = count == '0;
  assign full  = count == CW'(DEPTH);
endmodule

// File: rtl/ep4_cmd_deframer.sv
// ep4_cmd_deframer: parses id/len_h/len_l/payload frames from the USB byte stream
// and presents them on the EP4 command port with clamping and stall timeout.
module ep4_cmd_deframer
  import ep4_cmd_deframer_pkg::*;
#(
  parameter int MAX_COMMAND_LENGTH = DEF_MAX_COMMAND_LENGTH,
  parameter int TIMEOUT_CYCLES     = DEF_TIMEOUT_CYCLES,
  parameter int TIMEOUT_WIDTH      = DEF_TIMEOUT_WIDTH
) (
  input logic                clk,
  input logic                reset,
  ep4_cmd_deframer_if.master bus
);
  localparam int CW = $clog2(MAX_COMMAND_LENGTH) + 1;
  localparam logic [15:0] MAX16 = 16'(MAX_COMMAND_LENGTH);
  state_t             state, state_nx;
  logic               live, accept, run, tmo, push, pop, empty, full;
  logic [7:0]         id_q, len_h, head;
  logic [15:0]        len, len_in, rx_count;
  logic [CW-1:0]      count;
  logic [TIMEOUT_WIDTH-1:0] tcnt;
  assign len_in       = {len_h, bus.in_data};
  assign run          = state == HDR_LEN_H || state == HDR_LEN_L || state == PAYLOAD;
  // live holds in_ready low until the first edge after reset release
  assign bus.in_ready = live && (state == HDR_ID || run);
  assign accept       = bus.in_valid && bus.in_ready;
  assign tmo          = TIMEOUT_CYCLES != 0 && run && !accept &&
                        tcnt == TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= HDR_ID;
    else        state <= state_nx;
  end
  always_comb begin
    state_nx = state;
    if (tmo) state_nx = HDR_ID;
    else
      case (state)
        HDR_ID:    state_nx = accept ? HDR_LEN_H : HDR_ID;
        HDR_LEN_H: state_nx = accept ? HDR_LEN_L : HDR_LEN_H;
        HDR_LEN_L: state_nx = !accept ? HDR_LEN_L : len_in == '0 ? RETIRE : PAYLOAD;
        PAYLOAD:   state_nx = accept && 16'(rx_count + 16'd1) == len ? DRAIN : PAYLOAD;
        DRAIN:     state_nx = empty ? RETIRE : DRAIN;
        default:   state_nx = HDR_ID;
      endcase
  end
  always_comb begin
    push          = state == PAYLOAD && accept && rx_count < MAX16 && !full;
    bus.ep4_ready = bus.cmd_valid && count != '0;
    pop           = bus.ep4_read && bus.ep4_ready;
    bus.ep4_data  = empty ? 8'h00 : head;
  end
  // id/length are published together at the last header byte so they stay
  // stable across retire until the next frame's length is known
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      live               <= 1'b0;
      id_q               <= '0;
      len_h              <= '0;
      len                <= '0;
      rx_count           <= '0;
      tcnt               <= '0;
      bus.ep4_cmd_id     <= '0;
      bus.ep4_cmd_length <= '0;
      bus.cmd_valid      <= 1'b0;
      bus.err_oversize   <= 1'b0;
      bus.err_timeout    <= 1'b0;
    end else begin
      live             <= 1'b1;
      tcnt             <= run && !accept && !tmo ? tcnt + 1'b1 : '0;
      rx_count         <= state == PAYLOAD ? rx_count + 16'(accept) : '0;
      bus.err_oversize <= state == HDR_LEN_L && accept && len_in > MAX16;
      bus.err_timeout  <= tmo;
      if (state == HDR_ID && accept) id_q <= bus.in_data;
      if (state == HDR_LEN_H && accept) len_h <= bus.in_data;
      if (state == HDR_LEN_L && accept) begin
        len                <= len_in;
        bus.ep4_cmd_id     <= id_q;
        bus.ep4_cmd_length <= len_in > MAX16 ? MAX16 : len_in;
        bus.cmd_valid      <= 1'b1;
      end else if (tmo || state == RETIRE) bus.cmd_valid <= 1'b0;
    end
  end
  cmd_byte_fifo #(.DEPTH(MAX_COMMAND_LENGTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (tmo),
    .din   (bus.in_data),
    .head  (head),
    .empty (empty),
    .full  (full),
    .count (count)
  );
endmodule
